// File: rtl/param_counter_sb_if.sv
// Scoreboard bus for param_counter_sb: stimulus/DUT-under-check signals in, reference model and error status out.
// Capture outputs exist only when SB_ERR_CAPTURE_EN is defined.
interface param_counter_sb_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             dut_valid;
    logic [WIDTH-1:0] dut_q;
    logic             dut_rco;
    logic [WIDTH-1:0] q_model;
    logic             rco_model;
    logic             load_model;
    logic [ERR_W-1:0] err_cnt;
    logic             err_flag;
`ifdef SB_ERR_CAPTURE_EN
    logic             cap_valid;
    logic [WIDTH-1:0] cap_dut_q;
    logic [WIDTH-1:0] cap_model_q;
    logic [15:0]      cap_cycle;

    modport master (
        output enable, mode, d, dut_valid, dut_q, dut_rco,
        input  q_model, rco_model, load_model, err_cnt, err_flag,
        input  cap_valid, cap_dut_q, cap_model_q, cap_cycle
    );
    modport slave (
        input  enable, mode, d, dut_valid, dut_q, dut_rco,
        output q_model, rco_model, load_model, err_cnt, err_flag,
        output cap_valid, cap_dut_q, cap_model_q, cap_cycle
    );
`else
    modport master (
        output enable, mode, d, dut_valid, dut_q, dut_rco,
        input  q_model, rco_model, load_model, err_cnt, err_flag
    );
    modport slave (
        input  enable, mode, d, dut_valid, dut_q, dut_rco,
        output q_model, rco_model, load_model, err_cnt, err_flag
    );
`endif
endinterface

// File: rtl/param_counter_sb.sv
// Reference-model scoreboard for an up/down/down-by-STEP/load counter with saturating mismatch counter.
// Optional first-mismatch capture enabled by defining SB_ERR_CAPTURE_EN.
module param_counter_sb #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3,
    parameter int ERR_W = 8
) (
    input logic             clk,
    input logic             reset,
    param_counter_sb_if.slave sb
);
    localparam logic [WIDTH-1:0] Q_MAX  = '1;
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

    logic [WIDTH-1:0] q_p1;
    logic             rco_p1;
    logic             load_p1;
    logic [ERR_W-1:0] err_cnt_p1;
    logic             err_flag_p1;

    logic [WIDTH-1:0] q_nxt;
    logic             rco_nxt;
    logic             load_nxt;
    logic             mismatch;

    always_comb begin
        q_nxt    = q_p1;
        rco_nxt  = 1'b0;
        load_nxt = 1'b0;
        if (sb.enable) begin
            unique case (sb.mode)
                2'b00: begin
                    q_nxt   = q_p1 + WIDTH'(1);
                    rco_nxt = (q_p1 == Q_MAX);
                end
                2'b01: begin
                    q_nxt   = q_p1 - WIDTH'(1);
                    rco_nxt = (q_p1 == '0);
                end
                2'b10: begin
                    q_nxt   = q_p1 - STEP_V;
                    rco_nxt = (q_p1 < STEP_V);
                end
                default: begin
                    q_nxt    = sb.d;
                    load_nxt = 1'b1;
                end
            endcase
        end
    end

    // Compare against the model values registered before this edge
    assign mismatch = sb.dut_valid && ((sb.dut_q != q_p1) || (sb.dut_rco != rco_p1));

    // Stage p1: model state and error bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_p1        <= '0;
            rco_p1      <= 1'b0;
            load_p1     <= 1'b0;
            err_cnt_p1  <= '0;
            err_flag_p1 <= 1'b0;
        end else begin
            q_p1    <= q_nxt;
            rco_p1  <= rco_nxt;
            load_p1 <= load_nxt;
            if (mismatch) begin
                err_cnt_p1  <= sat_inc(err_cnt_p1);
                err_flag_p1 <= 1'b1;
            end
        end
    end

    assign sb.q_model    = q_p1;
    assign sb.rco_model  = rco_p1;
    assign sb.load_model = load_p1;
    assign sb.err_cnt    = err_cnt_p1;
    assign sb.err_flag   = err_flag_p1;

`ifdef SB_ERR_CAPTURE_EN
    logic [15:0]      cyc_p1;
    logic             cap_vld_p1;
    logic [WIDTH-1:0] cap_dut_q_p1;
    logic [WIDTH-1:0] cap_model_q_p1;
    logic [15:0]      cap_cycle_p1;

    // Stage p1: first-mismatch snapshot, frozen until reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_p1         <= '0;
            cap_vld_p1     <= 1'b0;
            cap_dut_q_p1   <= '0;
            cap_model_q_p1 <= '0;
            cap_cycle_p1   <= '0;
        end else begin
            cyc_p1 <= cyc_p1 + 16'd1;
            if (mismatch && !cap_vld_p1) begin
                cap_vld_p1     <= 1'b1;
                cap_dut_q_p1   <= sb.dut_q;
                cap_model_q_p1 <= q_p1;
                cap_cycle_p1   <= cyc_p1;
            end
        end
    end

    assign sb.cap_valid   = cap_vld_p1;
    assign sb.cap_dut_q   = cap_dut_q_p1;
    assign sb.cap_model_q = cap_model_q_p1;
    assign sb.cap_cycle   = cap_cycle_p1;
`endif
endmodule

// File: tb/tb_param_counter_sb.sv
// Directed-vector bench for param_counter_sb (WIDTH=4, STEP=3, ERR_W=8).
// Capture checks are included when SB_ERR_CAPTURE_EN is defined.
module tb_param_counter_sb;
    localparam int WIDTH = 4;
    localparam int STEP  = 3;
    localparam int ERR_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_counter_sb_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) sb_if ();

    param_counter_sb #(.WIDTH(WIDTH), .STEP(STEP), .ERR_W(ERR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag, input logic [31:0] q, input logic rco, input logic load);
        check({tag, ".q"}, 32'(sb_if.q_model), q);
        check({tag, ".rco"}, 32'(sb_if.rco_model), 32'(rco));
        check({tag, ".load"}, 32'(sb_if.load_model), 32'(load));
    endtask

    task automatic chk_err(input string tag, input logic [31:0] cnt, input logic flag);
        check({tag, ".err_cnt"}, 32'(sb_if.err_cnt), cnt);
        check({tag, ".err_flag"}, 32'(sb_if.err_flag), 32'(flag));
    endtask

    initial begin
        reset            = 1'b0;
        sb_if.enable     = 1'b0;
        sb_if.mode       = 2'b00;
        sb_if.d          = '0;
        sb_if.dut_valid  = 1'b0;
        sb_if.dut_q      = '0;
        sb_if.dut_rco    = 1'b0;
        tick();
        tick();
        chk_model("reset", 0, 1'b0, 1'b0);
        chk_err("reset", 0, 1'b0);

        // count up through wrap; rco only after q=15
        reset        = 1'b1;
        sb_if.enable = 1'b1;
        sb_if.mode   = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("up%0d.q", i), 32'(sb_if.q_model), 32'(i % 16));
            check($sformatf("up%0d.rco", i), 32'(sb_if.rco_model), (i == 16) ? 32'd1 : 32'd0);
        end

        // load 2, then down-by-3 twice
        sb_if.mode = 2'b11;
        sb_if.d    = 4'h2;
        tick();
        chk_model("load2", 2, 1'b0, 1'b1);
        sb_if.mode = 2'b10;
        tick();
        chk_model("step_wrap", 15, 1'b1, 1'b0);
        tick();
        chk_model("step12", 12, 1'b0, 1'b0);

        // load 0, count down across wrap, then hold
        sb_if.mode = 2'b11;
        sb_if.d    = 4'h0;
        tick();
        chk_model("load0", 0, 1'b0, 1'b1);
        sb_if.mode = 2'b01;
        tick();
        chk_model("down_wrap", 15, 1'b1, 1'b0);
        sb_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_model($sformatf("hold%0d", i), 15, 1'b0, 1'b0);
        end

        // matching compares, one rco mismatch, then invalid samples ignored
        sb_if.dut_valid = 1'b1;
        sb_if.dut_q     = 4'hF;
        sb_if.dut_rco   = 1'b0;
        tick();
        tick();
        chk_err("match", 0, 1'b0);
        sb_if.dut_rco = 1'b1;
        tick();
        chk_err("rco_mis", 1, 1'b1);
        sb_if.dut_valid = 1'b0;
        sb_if.dut_q     = 4'h3;
        tick();
        chk_err("novalid", 1, 1'b1);

        // saturation: dut_q = q_model+1 for 300 edges
        sb_if.dut_valid = 1'b1;
        sb_if.dut_q     = 4'h0;
        sb_if.dut_rco   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 252) chk_err("sat254", 254, 1'b1);
            if (i == 253) chk_err("sat255", 255, 1'b1);
        end
        chk_err("sat_end", 255, 1'b1);
        check("sat_hold_q", 32'(sb_if.q_model), 15);

        // clear, count to 7, then reset mid-count with mismatching compare
        reset           = 1'b0;
        sb_if.dut_valid = 1'b0;
        tick();
        chk_err("clr", 0, 1'b0);
        reset        = 1'b1;
        sb_if.enable = 1'b1;
        sb_if.mode   = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst.q", 32'(sb_if.q_model), 7);
        reset           = 1'b0;
        sb_if.dut_valid = 1'b1;
        sb_if.dut_q     = 4'h3;
        sb_if.dut_rco   = 1'b1;
        tick();
        chk_model("mid_rst", 0, 1'b0, 1'b0);
        chk_err("mid_rst", 0, 1'b0);

        // resume from 0; compare and advance on the same edge
        reset           = 1'b1;
        sb_if.dut_valid = 1'b0;
        tick();
        chk_model("resume", 1, 1'b0, 1'b0);
        sb_if.dut_valid = 1'b1;
        sb_if.dut_q     = 4'h1;
        sb_if.dut_rco   = 1'b0;
        tick();
        check("same_edge.q", 32'(sb_if.q_model), 2);
        chk_err("same_edge_ok", 0, 1'b0);
        sb_if.dut_q   = 4'h2;
        sb_if.dut_rco = 1'b1;
        tick();
        check("same_edge2.q", 32'(sb_if.q_model), 3);
        chk_err("same_edge_mis", 1, 1'b1);

`ifdef SB_ERR_CAPTURE_EN
        reset           = 1'b0;
        sb_if.dut_valid = 1'b0;
        tick();
        check("cap_rst.valid", 32'(sb_if.cap_valid), 0);
        check("cap_rst.cycle", 32'(sb_if.cap_cycle), 0);
        reset           = 1'b1;
        sb_if.enable    = 1'b1;
        sb_if.mode      = 2'b00;
        sb_if.dut_valid = 1'b1;
        sb_if.dut_rco   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sb_if.dut_q = 4'(k);
            tick();
        end
        check("cap_pre.valid", 32'(sb_if.cap_valid), 0);
        sb_if.dut_q = 4'h9;
        tick();
        check("cap.valid", 32'(sb_if.cap_valid), 1);
        check("cap.dut_q", 32'(sb_if.cap_dut_q), 9);
        check("cap.model_q", 32'(sb_if.cap_model_q), 5);
        check("cap.cycle", 32'(sb_if.cap_cycle), 5);
        sb_if.dut_q = 4'h0;
        tick();
        check("cap_hold.dut_q", 32'(sb_if.cap_dut_q), 9);
        check("cap_hold.model_q", 32'(sb_if.cap_model_q), 5);
        check("cap_hold.cycle", 32'(sb_if.cap_cycle), 5);
        chk_err("cap_errs", 2, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_counter_sb.md
PARAM_COUNTER_SB -- requirements
Module: param_counter_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 SHALL have parameter STEP, default 3, decrement amount in mode 2'b10 (1..2^WIDTH-1).
REQ-003 SHALL have parameter ERR_W, default 8, error-counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  model advance enable.
REQ-007 SHALL have port mode  input  2  00 up, 01 down, 10 down-by-STEP, 11 load.
REQ-008 SHALL have port d  input  WIDTH  load value.
REQ-009 SHALL have port dut_valid  input  1  DUT sample is valid for comparison this cycle.
REQ-010 SHALL have port dut_q  input  WIDTH  DUT count under check.
REQ-011 SHALL have port dut_rco  input  1  DUT ripple-carry under check.
REQ-012 SHALL have port q_model  output  WIDTH  reference count.
REQ-013 SHALL have port rco_model  output  1  reference ripple-carry pulse.
REQ-014 SHALL have port load_model  output  1  reference load pulse.
REQ-015 SHALL have port err_cnt  output  ERR_W  mismatch count.
REQ-016 SHALL have port err_flag  output  1  sticky any-mismatch flag.

Function
REQ-017 SHALL, with enable=1, compute next q_model per mode, modulo 2^WIDTH: up q+1; down q-1; down-by-STEP q-STEP; load d.
REQ-018 SHALL assert rco_model for exactly the cycle following an edge where: mode 00 and q=2^WIDTH-1; mode 01 and q=0; mode 10 and q<STEP; otherwise 0.
REQ-019 SHALL assert load_model for the cycle following an edge with enable=1 and mode 11; rco_model=0 in that cycle.
REQ-020 SHALL, with enable=0, hold q_model and drive rco_model=0, load_model=0 on the next edge.
REQ-021 SHALL compare on every edge with dut_valid=1: mismatch when dut_q!=q_model or dut_rco!=rco_model (pre-edge registered model values).
REQ-022 SHALL increment err_cnt by 1 per mismatching compare, saturating at 2^ERR_W-1.
REQ-023 SHALL set err_flag on first mismatch and hold it until reset.
REQ-024 SHALL perform no compare when dut_valid=0; compare is independent of enable.
REQ-025 SHALL handle compare and model update on the same edge: compare uses old model, model advances.
REQ-026 SHALL produce model output latency of exactly one clock from inputs.

Reset
REQ-027 SHALL, on edge with reset=0, clear q_model, rco_model, load_model, err_cnt, err_flag to 0, overriding enable, mode, dut_valid.
REQ-028 SHALL, on reset mid-operation, discard pending pulses and any compare on that edge.
REQ-029 SHALL, on first edge after reset=1, resume from q_model=0.

Configuration
REQ-030 SHALL, with macro SB_ERR_CAPTURE_EN defined, add outputs cap_valid (1), cap_dut_q (WIDTH), cap_model_q (WIDTH), cap_cycle (16) latching first mismatch's dut_q, q_model and free-running post-reset cycle count; no overwrite until reset; all cleared by reset.
REQ-031 SHALL, without SB_ERR_CAPTURE_EN, omit those ports and the cycle counter entirely; all other behaviour identical.

Verification (WIDTH=4, STEP=3, ERR_W=8)
REQ-032 SHALL cover: reset=0, then enable=1 mode=00 for 16 edges -> q_model 1..15,0; rco_model=1 only in cycle after q=15.
REQ-033 SHALL cover: load d=4'h2 then mode=10 -> load_model pulse, q=2, next q=15 with rco_model=1, then q=12 with rco_model=0.
REQ-034 SHALL cover: mode=01 from q=0 -> q=15, rco_model=1 one cycle; enable=0 for 3 edges -> q holds 15, rco_model=0.
REQ-035 SHALL cover: dut_valid=1 with dut_q=q_model+1 for 300 edges -> err_cnt saturates at 255, err_flag=1.
REQ-036 SHALL cover: reset=0 asserted mid-count at q=7 with dut_valid=1 mismatching -> all outputs 0 next cycle, err_cnt unchanged from 0.
REQ-037 SHALL cover, with SB_ERR_CAPTURE_EN: first mismatch at cycle 5 with dut_q=9, q_model=5 -> cap_valid=1, cap_dut_q=9, cap_model_q=5, cap_cycle=5; later mismatches leave capture unchanged.
